// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
//   Instruction-fetch front end. Owns the fetch PC and drives a ROM with a
//   synchronous read. Fetched words go into a small prefetch FIFO, and the
//   ID stage drains that FIFO through a valid/ready handshake. The unit also
//   handles absolute and relative redirects, and it suspends and restarts
//   fetching around UART programming.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   uart_disable         1 = run, 0 = UART programming (fetch suspended)
//   pc_overload(_value)  absolute redirect request / target byte address
//   pc_offset(_base/_value) relative redirect: base + (word offset << 2)
//   id_ready             ID stage accepts the head entry this cycle
//   rom_en, rom_addr     ROM read strobe and word address
//   rom_data             ROM data, valid the cycle after rom_en
//   if_valid, if_no_op   head entry valid / its complement
//   if_instruction       head instruction word
//   if_pc                head instruction address + 4
//   pc_reset             one-cycle pulse when UART programming ends
//   queue_count          number of occupied FIFO entries
// ---------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int                    ISA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH  = 14,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ISA_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            uart_disable,
  input  logic                            pc_overload,
  input  logic [ISA_WIDTH-1:0]            pc_overload_value,
  input  logic                            pc_offset,
  input  logic [ISA_WIDTH-1:0]            pc_offset_base,
  input  logic [ISA_WIDTH-1:0]            pc_offset_value,
  input  logic                            id_ready,
  output logic                            rom_en,
  output logic [ADDR_WIDTH-1:0]           rom_addr,
  input  logic [ISA_WIDTH-1:0]            rom_data,
  output logic                            if_valid,
  output logic                            if_no_op,
  output logic [ISA_WIDTH-1:0]            if_instruction,
  output logic [ISA_WIDTH-1:0]            if_pc,
  output logic                            pc_reset,
  output logic [$clog2(QUEUE_DEPTH):0]    queue_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(QUEUE_DEPTH);
  localparam logic [ISA_WIDTH-1:0] LOW_MASK = ~(ISA_WIDTH'(3));

  logic [ISA_WIDTH-1:0] fetch_pc_reg;
  logic [ISA_WIDTH-1:0] instr_mem [QUEUE_DEPTH];
  logic [ISA_WIDTH-1:0] pc_mem    [QUEUE_DEPTH];
  logic [PW-1:0]        head_reg;
  logic [PW-1:0]        tail_reg;
  logic [CW-1:0]        count_reg;
  logic                 inflight_reg;
  logic [ISA_WIDTH-1:0] inflight_pc_reg;
  logic                 uart_prev_reg;
  logic [ISA_WIDTH-1:0] out_instr_reg;
  logic [ISA_WIDTH-1:0] out_pc_reg;

  logic                 suspend;
  logic                 flush;
  logic                 pop;
  logic                 push;
  logic                 issue;
  logic [CW:0]          occupancy;
  logic [PW-1:0]        head_next;
  logic [CW-1:0]        remain_after_pop;
  logic [ISA_WIDTH-1:0] redirect_target;

  assign suspend = ~uart_disable;
  assign flush   = suspend | pc_overload | pc_offset;

  // The valid output is masked during suspend. The ID stage then never sees
  // an entry that is about to be flushed.
  assign if_valid = (count_reg != '0) & uart_disable;
  assign if_no_op = ~if_valid;
  assign pop      = if_valid & id_ready;
  // A response that arrives in a flush cycle belongs to the old stream and is
  // dropped here.
  assign push     = inflight_reg & ~flush;

  // Slots committed after this cycle: stored entries plus the response in
  // flight, minus any entry popped this cycle.
  assign occupancy = {1'b0, count_reg} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
  // Gating with rst_n keeps the ROM idle while reset is asserted.
  assign issue     = rst_n & ~flush & (occupancy < DEPTH_C);

  assign rom_en   = issue;
  assign rom_addr = issue ? fetch_pc_reg[ADDR_WIDTH+1:2] : '0;
  assign pc_reset = rst_n & uart_disable & ~uart_prev_reg;

  assign redirect_target = pc_overload
                         ? (pc_overload_value & LOW_MASK)
                         : ((pc_offset_base + (pc_offset_value << 2)) & LOW_MASK);

  assign head_next        = head_reg + PW'(pop);
  assign remain_after_pop = count_reg - CW'(pop);

  assign if_instruction = out_instr_reg;
  assign if_pc          = out_pc_reg;
  assign queue_count    = count_reg;

  // FIFO storage. There is no reset here, so the memory stays RAM-like.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_reg] <= rom_data;
      pc_mem[tail_reg]    <= inflight_pc_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      uart_prev_reg   <= 1'b1;
      out_instr_reg   <= '0;
      out_pc_reg      <= '0;
    end else begin
      uart_prev_reg <= uart_disable;
      inflight_reg  <= issue;
      if (issue) begin
        inflight_pc_reg <= fetch_pc_reg + ISA_WIDTH'(4);
      end

      if (suspend) begin
        fetch_pc_reg <= RESET_PC;
      end else if (pc_overload | pc_offset) begin
        fetch_pc_reg <= redirect_target;
      end else if (issue) begin
        fetch_pc_reg <= fetch_pc_reg + ISA_WIDTH'(4);
      end

      if (flush) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        head_reg  <= head_next;
        count_reg <= count_reg + CW'(push) - CW'(pop);
        if (push) begin
          tail_reg <= tail_reg + PW'(1);
        end
        // The head output registers follow the next head entry. When the
        // queue drains they keep the last value. When only the incoming word
        // will be left, that word becomes the new head directly.
        if (remain_after_pop != '0) begin
          out_instr_reg <= instr_mem[head_next];
          out_pc_reg    <= pc_mem[head_next];
        end else if (push) begin
          out_instr_reg <= rom_data;
          out_pc_reg    <= inflight_pc_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  logic        clk;
  logic        rst_n;
  logic        uart_disable;
  logic        pc_overload;
  logic [31:0] pc_overload_value;
  logic        pc_offset;
  logic [31:0] pc_offset_base;
  logic [31:0] pc_offset_value;
  logic        id_ready;
  logic        rom_en;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic        if_valid;
  logic        if_no_op;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        pc_reset;
  logic [2:0]  queue_count;

  int checks = 0;
  int errors = 0;

  fetch_queue_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .uart_disable      (uart_disable),
    .pc_overload       (pc_overload),
    .pc_overload_value (pc_overload_value),
    .pc_offset         (pc_offset),
    .pc_offset_base    (pc_offset_base),
    .pc_offset_value   (pc_offset_value),
    .id_ready          (id_ready),
    .rom_en            (rom_en),
    .rom_addr          (rom_addr),
    .rom_data          (rom_data),
    .if_valid          (if_valid),
    .if_no_op          (if_no_op),
    .if_instruction    (if_instruction),
    .if_pc             (if_pc),
    .pc_reset          (pc_reset),
    .queue_count       (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word i holds 0x1000_0000 + i, synchronous read
  always_ff @(posedge clk) begin
    if (rom_en) rom_data <= 32'h1000_0000 + {18'b0, rom_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rom_en"}, 32'(rom_en), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_if_valid"}, 32'(if_valid), 0);
    chk({tag, "_if_no_op"}, 32'(if_no_op), 1);
    chk({tag, "_if_instr"}, if_instruction, 0);
    chk({tag, "_if_pc"}, if_pc, 0);
    chk({tag, "_pc_reset"}, 32'(pc_reset), 0);
    chk({tag, "_count"}, 32'(queue_count), 0);
  endtask

  int pulses;
  int idx;

  initial begin
    rst_n = 1'b0; uart_disable = 1'b1; pc_overload = 1'b0; pc_overload_value = '0;
    pc_offset = 1'b0; pc_offset_base = '0; pc_offset_value = '0; id_ready = 1'b1;
    rom_data = '0;
    #1;
    chk_reset_outputs("reset");
    #1 rst_n = 1'b1;
    #1;
    // streaming with id_ready=1
    chk("s0_rom_en", 32'(rom_en), 1);
    chk("s0_rom_addr", 32'(rom_addr), 0);
    chk("s0_if_valid", 32'(if_valid), 0);
    for (int k = 1; k < 8; k++) begin
      step(); #1;
      $display("stream cycle %0d rom_addr=%h if_valid=%0d instr=%h pc=%h", k, rom_addr, if_valid, if_instruction, if_pc);
      chk("stream_rom_addr", 32'(rom_addr), 32'(k));
      if (k == 1) chk("stream_valid_c1", 32'(if_valid), 0);
      else begin
        chk("stream_valid", 32'(if_valid), 1);
        chk("stream_instr", if_instruction, 32'h1000_0000 + 32'(k - 2));
        chk("stream_pc", if_pc, 32'(4 * (k - 1)));
      end
    end

    // stall to 3 entries, then hit reset
    step(); id_ready = 1'b0; #1;
    for (int i = 0; i < 10; i++) begin
      if (queue_count == 3'd3) break;
      step(); #1;
    end
    chk("fill3", 32'(queue_count), 3);
    rst_n = 1'b0; #1;
    $display("async reset mid-run count=%0d", queue_count);
    chk_reset_outputs("midrst");
    step(); rst_n = 1'b1; #1;
    chk("refetch_rom_en", 32'(rom_en), 1);
    chk("refetch_rom_addr", 32'(rom_addr), 0);

    // id_ready=0 from start: exactly QUEUE_DEPTH fetches
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      pulses += int'(rom_en);
      step(); #1;
    end
    $display("stall fill pulses=%0d count=%0d", pulses, queue_count);
    chk("fill_pulses", 32'(pulses), 4);
    chk("fill_count", 32'(queue_count), 4);
    chk("fill_rom_en", 32'(rom_en), 0);
    step(); id_ready = 1'b1; #1;
    idx = 0;
    for (int i = 0; i < 12; i++) begin
      $display("drain pop instr=%h pc=%h", if_instruction, if_pc);
      chk("drain_valid", 32'(if_valid), 1);
      chk("drain_instr", if_instruction, 32'h1000_0000 + 32'(idx));
      chk("drain_pc", if_pc, 32'(4 * (idx + 1)));
      idx++;
      step(); #1;
    end

    // absolute redirect
    pc_overload = 1'b1; pc_overload_value = 32'h0000_0103; #1;
    chk("ovl_rom_en_n", 32'(rom_en), 0);
    step(); pc_overload = 1'b0; #1;
    $display("overload N+1 count=%0d rom_addr=%h", queue_count, rom_addr);
    chk("ovl_count", 32'(queue_count), 0);
    chk("ovl_rom_en", 32'(rom_en), 1);
    chk("ovl_rom_addr", 32'(rom_addr), 32'h40);
    chk("ovl_valid_n1", 32'(if_valid), 0);
    step(); #1;
    chk("ovl_valid_n2", 32'(if_valid), 0);
    step(); #1;
    $display("overload N+3 instr=%h pc=%h", if_instruction, if_pc);
    chk("ovl_valid_n3", 32'(if_valid), 1);
    chk("ovl_pc", if_pc, 32'h104);
    chk("ovl_instr", if_instruction, 32'h1000_0040);

    // overload beats offset
    pc_overload = 1'b1; pc_overload_value = 32'h80;
    pc_offset = 1'b1; pc_offset_base = 32'h20; pc_offset_value = 32'hFFFF_FFFE; #1;
    chk("both_rom_en_n", 32'(rom_en), 0);
    step(); pc_overload = 1'b0; pc_offset = 1'b0; #1;
    $display("both redirect rom_addr=%h", rom_addr);
    chk("both_rom_addr", 32'(rom_addr), 32'h20);
    step(); step(); #1;
    chk("both_pc", if_pc, 32'h84);
    chk("both_instr", if_instruction, 32'h1000_0020);

    // offset alone: 0x20 + (-2 << 2) = 0x18
    pc_offset = 1'b1; #1;
    chk("off_rom_en_n", 32'(rom_en), 0);
    step(); pc_offset = 1'b0; #1;
    $display("offset redirect rom_addr=%h", rom_addr);
    chk("off_rom_addr", 32'(rom_addr), 32'h6);
    step(); step(); #1;
    chk("off_pc", if_pc, 32'h1C);
    chk("off_instr", if_instruction, 32'h1000_0006);

    // UART programming window
    uart_disable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      $display("uart low cycle %0d valid=%0d rom_en=%0d", i, if_valid, rom_en);
      chk("uart_valid", 32'(if_valid), 0);
      chk("uart_rom_en", 32'(rom_en), 0);
      chk("uart_pc_reset", 32'(pc_reset), 0);
      step();
    end
    uart_disable = 1'b1; #1;
    $display("uart rise pc_reset=%0d rom_addr=%h", pc_reset, rom_addr);
    chk("rise_pc_reset", 32'(pc_reset), 1);
    chk("rise_rom_en", 32'(rom_en), 1);
    chk("rise_rom_addr", 32'(rom_addr), 0);
    chk("rise_no_op", 32'(if_no_op), 1);
    step(); #1;
    chk("rise1_pc_reset", 32'(pc_reset), 0);
    chk("rise1_rom_addr", 32'(rom_addr), 1);
    step(); #1;
    $display("uart restart instr=%h pc=%h", if_instruction, if_pc);
    chk("rise2_valid", 32'(if_valid), 1);
    chk("rise2_instr", if_instruction, 32'h1000_0000);
    chk("rise2_pc", if_pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
